// File: rtl/frame_buffer_arbiter_pkg.sv
// Shared definitions for the frame buffer arbiter: default widths, pixel address
// field offsets and the RAM slot encoding.
package frame_buffer_arbiter_pkg;
  localparam int ADDR_W   = 11;
  localparam int DATA_W   = 16;
  localparam int COL_LSB  = 0;
  localparam int ROW_LSB  = 6;
  localparam int HALF_BIT = 10;
  localparam int RD_LAT   = 2;

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_SCAN  = 2'd1,
    SLOT_WRITE = 2'd2
  } slot_e;
endpackage

// File: rtl/frame_buffer_arbiter_bank_swap_ctrl.sv
// Double-buffer bank control: holds a requested swap until the next frame start,
// then flips the display bank and pulses swap_done on that same edge.
module bank_swap_ctrl (
  input  logic clk_in,
  input  logic reset,
  input  logic swap_req_i,
  input  logic frame_start_i,
  output logic display_bank_o,
  output logic swap_pending_o,
  output logic swap_done_o
);
  logic bank_q, bank_d;
  logic pend_q, pend_d;
  logic done_q, done_d;
  logic fire;

  // A swap request arriving with frame_start swaps immediately.
  assign fire = frame_start_i && (pend_q || swap_req_i);

  always_comb begin
    bank_d = bank_q ^ fire;
    pend_d = fire ? 1'b0 : (pend_q || swap_req_i);
    done_d = fire;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      bank_q <= 1'b0;
      pend_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      bank_q <= bank_d;
      pend_q <= pend_d;
      done_q <= done_d;
    end
  end

  assign display_bank_o = bank_q;
  assign swap_pending_o = pend_q;
  assign swap_done_o    = done_q;
endmodule

// File: rtl/frame_buffer_arbiter.sv
// Arbitrates one single-port pixel RAM between scan-out reads (absolute priority,
// fixed 2-cycle latency) and host writes into the non-displayed bank.
module frame_buffer_arbiter #(
  parameter int ADDR_W = frame_buffer_arbiter_pkg::ADDR_W,
  parameter int DATA_W = frame_buffer_arbiter_pkg::DATA_W
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              scan_req,
  input  logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_data,
  output logic              scan_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              swap_req,
  input  logic              frame_start,
  output logic              swap_done,
  output logic              display_bank,
  output logic [ADDR_W:0]   mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import frame_buffer_arbiter_pkg::*;

  slot_e             slot_q, slot_d;
  logic [ADDR_W:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] scan_data_q;
  logic [RD_LAT:0]   vld_pipe;
  logic              swap_pending;

  bank_swap_ctrl u_swap (
    .clk_in         (clk_in),
    .reset          (reset),
    .swap_req_i     (swap_req),
    .frame_start_i  (frame_start),
    .display_bank_o (display_bank),
    .swap_pending_o (swap_pending),
    .swap_done_o    (swap_done)
  );

  // Writes are held off while a swap is queued so the bank queued for display stays intact.
  assign wr_ready = !reset && !scan_req && !swap_pending;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) slot_q <= SLOT_IDLE;
    else       slot_q <= slot_d;
  end

  always_comb begin
    slot_d = SLOT_IDLE;
    if (scan_req)                  slot_d = SLOT_SCAN;
    else if (wr_valid && wr_ready) slot_d = SLOT_WRITE;
  end

  // Bank bit is sampled here, so a read issued on the swap edge still sees the old bank.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (slot_d)
      SLOT_SCAN:  mem_addr_d = {display_bank, scan_addr};
      SLOT_WRITE: begin
        mem_addr_d  = {~display_bank, wr_addr};
        mem_wdata_d = wr_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      scan_data_q <= '0;
      vld_pipe    <= '0;
    end else begin
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      vld_pipe    <= {vld_pipe[RD_LAT-1:0], slot_d == SLOT_SCAN};
      if (vld_pipe[RD_LAT-1]) scan_data_q <= mem_rdata;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_we     = (slot_q == SLOT_WRITE);
  assign mem_wdata  = mem_wdata_q;
  assign scan_data  = scan_data_q;
  assign scan_valid = vld_pipe[RD_LAT];
endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed bench for frame_buffer_arbiter with a behavioural single-port RAM whose
// unwritten locations return a fixed pattern derived from the address.
module tb_frame_buffer_arbiter;
  localparam int AW = 11;
  localparam int DW = 16;

  logic          clk_in = 1'b0;
  logic          reset = 1'b1;
  logic          scan_req = 1'b0;
  logic [AW-1:0] scan_addr = '0;
  logic [DW-1:0] scan_data;
  logic          scan_valid;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          swap_req = 1'b0;
  logic          frame_start = 1'b0;
  logic          swap_done;
  logic          display_bank;
  logic [AW:0]   mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int n_chk = 0;
  int n_err = 0;

  frame_buffer_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_in(clk_in), .reset(reset),
    .scan_req(scan_req), .scan_addr(scan_addr), .scan_data(scan_data), .scan_valid(scan_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .frame_start(frame_start), .swap_done(swap_done),
    .display_bank(display_bank),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk_in = ~clk_in;

  // Preload pattern: bank 0 -> 0x4000|addr, bank 1 -> 0x8000|addr.
  function automatic logic [DW-1:0] pat(input logic [AW:0] a);
    return a[AW] ? (16'h8000 | {5'd0, a[AW-1:0]}) : (16'h4000 | {5'd0, a[AW-1:0]});
  endfunction

  bit [DW-1:0] ram   [0:(1<<(AW+1))-1];
  bit          wrote [0:(1<<(AW+1))-1];
  always @(posedge clk_in) begin
    if (mem_we) begin
      ram[mem_addr]   <= mem_wdata;
      wrote[mem_addr] <= 1'b1;
    end
    mem_rdata <= wrote[mem_addr] ? ram[mem_addr] : pat(mem_addr);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    // reset state
    repeat (2) tick();
    chk("rst_valid", scan_valid, 0);
    chk("rst_data", scan_data, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_bank", display_bank, 0);
    chk("rst_done", swap_done, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_wdata", mem_wdata, 0);
    reset = 1'b0;
    tick();

    // 1: 64 back-to-back scan reads from bank 0
    for (int i = 0; i < 68; i++) begin
      scan_req  = (i < 64);
      scan_addr = AW'(i);
      tick();
      chk("t1_valid", scan_valid, (i >= 2 && i < 66));
      if (i >= 2 && i < 66) chk("t1_data", scan_data, pat(12'(i - 2)));
    end
    scan_req = 1'b0;

    // 2: writer held on, scan alternating
    wr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      scan_req  = (i % 2 == 0);
      scan_addr = AW'(i + 8);
      wr_addr   = AW'(12'h200 + i);
      wr_data   = 16'hB000 + 16'(i);
      #1;
      chk("t2_wr_ready", wr_ready, !scan_req);
      tick();
      if (i % 2 == 0) begin
        chk("t2_scan_addr", mem_addr, {1'b0, AW'(i + 8)});
        chk("t2_scan_we", mem_we, 0);
      end else begin
        chk("t2_wr_addr", mem_addr, {1'b1, AW'(12'h200 + i)});
        chk("t2_wr_we", mem_we, 1);
        chk("t2_wr_data", mem_wdata, 16'hB000 + 16'(i));
      end
      chk("t2_valid", scan_valid, (i % 2 == 0 && i >= 2));
      if (i % 2 == 0 && i >= 2) chk("t2_data", scan_data, pat(12'(i - 2 + 8)));
    end
    wr_valid = 1'b0;
    scan_req = 1'b0;
    tick();
    chk("t2_last_valid", scan_valid, 1);
    chk("t2_last_data", scan_data, 16'h400E);
    tick();
    chk("t2_tail_valid", scan_valid, 0);
    chk("t2_land", ram[12'hA01], 16'hB001);
    chk("t2_land7", ram[12'hA07], 16'hB007);
    chk("t2_no_land", wrote[12'hA00], 0);

    // 3: write, swap request, swap at frame start, read back new bank
    wr_valid = 1'b1; wr_addr = 11'h123; wr_data = 16'hA5A5;
    #1;
    chk("t3_wr_ready", wr_ready, 1);
    tick();
    chk("t3_we", mem_we, 1);
    chk("t3_addr", mem_addr, 12'h923);
    wr_valid = 1'b0;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    wr_valid = 1'b1; wr_addr = 11'h050; wr_data = 16'hDEAD;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t3_pend_ready", wr_ready, 0);
      tick();
      chk("t3_pend_we", mem_we, 0);
      chk("t3_pend_bank", display_bank, 0);
    end
    wr_valid = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("t3_done", swap_done, 1);
    chk("t3_bank", display_bank, 1);
    tick();
    chk("t3_done_pulse", swap_done, 0);
    chk("t3_ready_back", wr_ready, 1);
    scan_req = 1'b1; scan_addr = 11'h123;
    tick();
    chk("t3_rd_addr", mem_addr, 12'h923);
    scan_req = 1'b0;
    tick();
    chk("t3_rd_early", scan_valid, 0);
    tick();
    chk("t3_rd_valid", scan_valid, 1);
    chk("t3_rd_data", scan_data, 16'hA5A5);

    // 4: simultaneous swap_req/frame_start, idle frame_start, repeated swap_req
    swap_req = 1'b1; frame_start = 1'b1;
    #1;
    chk("t4_ready_pre", wr_ready, 1);
    tick();
    swap_req = 1'b0; frame_start = 1'b0;
    chk("t4_done", swap_done, 1);
    chk("t4_bank", display_bank, 0);
    chk("t4_ready", wr_ready, 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("t4_idle_fs_done", swap_done, 0);
    chk("t4_idle_fs_bank", display_bank, 0);
    swap_req = 1'b1; tick(); swap_req = 1'b0; tick();
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    chk("t4_pend_ready", wr_ready, 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("t4_rep_done", swap_done, 1);
    chk("t4_rep_bank", display_bank, 1);
    tick();
    chk("t4_rep_done_off", swap_done, 0);
    chk("t4_rep_bank_hold", display_bank, 1);
    chk("t4_rep_ready", wr_ready, 1);

    // 5: read on the swap edge uses the old bank, the next read the new one
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    frame_start = 1'b1; scan_req = 1'b1; scan_addr = 11'h005;
    tick();
    frame_start = 1'b0;
    chk("t5_old_addr", mem_addr, 12'h805);
    chk("t5_bank", display_bank, 0);
    chk("t5_done", swap_done, 1);
    scan_addr = 11'h006;
    tick();
    scan_req = 1'b0;
    chk("t5_new_addr", mem_addr, 12'h006);
    tick();
    chk("t5_v0", scan_valid, 1);
    chk("t5_d0", scan_data, 16'h8005);
    tick();
    chk("t5_v1", scan_valid, 1);
    chk("t5_d1", scan_data, 16'h4006);
    tick();
    chk("t5_v2", scan_valid, 0);

    // 6: reset with a swap pending and two reads in flight
    swap_req = 1'b1; frame_start = 1'b1; tick();
    swap_req = 1'b0; frame_start = 1'b0;
    chk("t6_bank_pre", display_bank, 1);
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    scan_req = 1'b1; scan_addr = 11'h030; tick();
    scan_addr = 11'h031; tick();
    scan_req = 1'b0;
    reset = 1'b1;
    #1;
    chk("t6_valid", scan_valid, 0);
    chk("t6_data", scan_data, 0);
    chk("t6_addr", mem_addr, 0);
    chk("t6_we", mem_we, 0);
    chk("t6_wdata", mem_wdata, 0);
    chk("t6_bank", display_bank, 0);
    chk("t6_done", swap_done, 0);
    chk("t6_ready", wr_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_hold_valid", scan_valid, 0);
    end
    reset = 1'b0;
    tick();
    chk("t6_post_valid", scan_valid, 0);
    chk("t6_post_ready", wr_ready, 1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("t6_lost_done", swap_done, 0);
    chk("t6_lost_bank", display_bank, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
